// File: rtl/div_unit_pkg.sv
// -----------------------------------------------------------------------------
// div_unit_pkg
// Shared definitions for the EXU execution units: the ALU op width, the
// divider op encoding (bit positions plus the eight RV64M divide/remainder
// encodings), the divider state encoding and the datapath/word widths.
//
// Optional feature macro used by div_unit: DIV_FAST_SPECIAL_EN.
// -----------------------------------------------------------------------------
package div_unit_pkg;

  // Datapath widths
  localparam int XLEN_W   = 64;
  localparam int WORD_W   = XLEN_W / 2;

  // Existing combinational ALU op width
  localparam int ALU_OP_W = 4;

  // Divider op field: bit0 = unsigned, bit1 = remainder, bit2 = word
  localparam int DIV_OP_W        = 3;
  localparam int DIV_OP_UNSIGNED = 0;
  localparam int DIV_OP_REM      = 1;
  localparam int DIV_OP_WORD     = 2;

  localparam logic [DIV_OP_W-1:0] DivDiv   = 3'b000;
  localparam logic [DIV_OP_W-1:0] DivDivu  = 3'b001;
  localparam logic [DIV_OP_W-1:0] DivRem   = 3'b010;
  localparam logic [DIV_OP_W-1:0] DivRemu  = 3'b011;
  localparam logic [DIV_OP_W-1:0] DivDivw  = 3'b100;
  localparam logic [DIV_OP_W-1:0] DivDivuw = 3'b101;
  localparam logic [DIV_OP_W-1:0] DivRemw  = 3'b110;
  localparam logic [DIV_OP_W-1:0] DivRemuw = 3'b111;

  // Divider control states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_unit_prep.sv
// -----------------------------------------------------------------------------
// div_prep
// Combinational operand conditioning for the divider.
//   div_op      : op field (unsigned / remainder / word)
//   operator_1  : raw dividend
//   operator_2  : raw divisor
//   op1_ext     : dividend after word sign/zero extension
//   op2_ext     : divisor after word sign/zero extension
//   abs1, abs2  : magnitudes fed to the unsigned iteration
//   sign_q      : quotient must be negated (signed ops only)
//   sign_r      : remainder must be negated (signed ops only)
//   div_zero    : divisor is zero
//   overflow    : signed most-negative / -1
// Feeding already-extended operands back through gives the same values, which
// lets one instance serve both the accept path and the final fix-up.
// -----------------------------------------------------------------------------
module div_prep
  import div_unit_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [DIV_OP_W-1:0] div_op,
  input  logic [XLEN-1:0]     operator_1,
  input  logic [XLEN-1:0]     operator_2,
  output logic [XLEN-1:0]     op1_ext,
  output logic [XLEN-1:0]     op2_ext,
  output logic [XLEN-1:0]     abs1,
  output logic [XLEN-1:0]     abs2,
  output logic                sign_q,
  output logic                sign_r,
  output logic                div_zero,
  output logic                overflow
);

  localparam int HW = XLEN / 2;

  logic                   is_signed;
  logic                   is_word;
  logic                   neg1;
  logic                   neg2;
  logic [XLEN-1:0]        min_neg;
  logic signed [XLEN-1:0] op1_s;
  logic signed [XLEN-1:0] op2_s;

  always_comb begin
    is_signed = !div_op[DIV_OP_UNSIGNED];
    is_word   = div_op[DIV_OP_WORD];

    if (is_word) begin
      op1_ext = {{HW{is_signed & operator_1[HW-1]}}, operator_1[HW-1:0]};
      op2_ext = {{HW{is_signed & operator_2[HW-1]}}, operator_2[HW-1:0]};
      // Most-negative word value as it appears after sign extension
      min_neg = {{(HW+1){1'b1}}, {(HW-1){1'b0}}};
    end else begin
      op1_ext = operator_1;
      op2_ext = operator_2;
      min_neg = {1'b1, {(XLEN-1){1'b0}}};
    end

    op1_s = $signed(op1_ext);
    op2_s = $signed(op2_ext);
    neg1  = is_signed & op1_ext[XLEN-1];
    neg2  = is_signed & op2_ext[XLEN-1];

    // Most-negative maps onto itself, which is the correct unsigned magnitude
    abs1 = neg1 ? $unsigned(-op1_s) : op1_ext;
    abs2 = neg2 ? $unsigned(-op2_s) : op2_ext;

    sign_q   = neg1 ^ neg2;
    sign_r   = neg1;
    div_zero = (op2_ext == '0);
    overflow = is_signed && (op1_ext == min_neg) && (op2_ext == '1);
  end

endmodule

// File: rtl/div_unit.sv
// -----------------------------------------------------------------------------
// div_unit
// Iterative radix-2 restoring divider for RV64M DIV/DIVU/REM/REMU and the
// W forms. One operation in flight, valid/ready on both sides.
//   clk, rst_n  : clock (rising edge), asynchronous active-low reset
//   in_valid    : request valid
//   in_ready    : high only while idle
//   div_op      : bit0 unsigned, bit1 remainder, bit2 word
//   operator_1  : dividend
//   operator_2  : divisor
//   flush       : kills the operation in progress (ignored while idle,
//                 cancels a same-cycle accept)
//   out_valid   : result valid, held until out_ready
//   out_ready   : consumer accepts the result
//   div_result  : quotient or remainder (word results sign-extended)
// Latency from accept to out_valid is N+2 cycles (N = 64, or 32 for word).
// With DIV_FAST_SPECIAL_EN defined, divide-by-zero and signed overflow skip
// the iteration and present their result one cycle after accept.
// -----------------------------------------------------------------------------
module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int CNT_W = 7
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DIV_OP_W-1:0] div_op,
  input  logic [XLEN-1:0]     operator_1,
  input  logic [XLEN-1:0]     operator_2,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     div_result
);

  localparam int HW = XLEN / 2;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(XLEN);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HW);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  div_state_e          state;
  logic [DIV_OP_W-1:0] op_q;
  logic [XLEN-1:0]     op1_q;
  logic [XLEN-1:0]     op2_q;
  logic [XLEN-1:0]     dvs_q;
  logic [XLEN-1:0]     rem_q;
  logic [XLEN-1:0]     quo_q;
  logic                neg_q_q;
  logic                neg_r_q;
  logic [CNT_W-1:0]    cnt_q;

  logic                idle;
  logic                accept;
  logic [DIV_OP_W-1:0] prep_op;
  logic [XLEN-1:0]     prep_a;
  logic [XLEN-1:0]     prep_b;
  logic [XLEN-1:0]     prep_op1_ext;
  logic [XLEN-1:0]     prep_op2_ext;
  logic [XLEN-1:0]     prep_abs1;
  logic [XLEN-1:0]     prep_abs2;
  logic                prep_sign_q;
  logic                prep_sign_r;
  logic                prep_div_zero;
  logic                prep_overflow;

  logic [XLEN:0]       rem_sh;
  logic [XLEN:0]       trial;
  logic                trial_neg;
  logic [XLEN-1:0]     rem_next;
  logic [XLEN-1:0]     quo_next;

  assign idle     = (state == S_IDLE);
  assign in_ready = idle;
  assign accept   = idle && in_valid && !flush;

  // While idle the prep block looks at the incoming request; afterwards it
  // re-evaluates the latched (already extended) operands for the fix-up.
  assign prep_op = idle ? div_op     : op_q;
  assign prep_a  = idle ? operator_1 : op1_q;
  assign prep_b  = idle ? operator_2 : op2_q;

  div_prep #(
    .XLEN (XLEN)
  ) u_prep (
    .div_op     (prep_op),
    .operator_1 (prep_a),
    .operator_2 (prep_b),
    .op1_ext    (prep_op1_ext),
    .op2_ext    (prep_op2_ext),
    .abs1       (prep_abs1),
    .abs2       (prep_abs2),
    .sign_q     (prep_sign_q),
    .sign_r     (prep_sign_r),
    .div_zero   (prep_div_zero),
    .overflow   (prep_overflow)
  );

  // Final result: sign correction, special-case override, word extension
  function automatic logic [XLEN-1:0] finalize(
    input logic [DIV_OP_W-1:0] op,
    input logic [XLEN-1:0]     quo,
    input logic [XLEN-1:0]     rem,
    input logic [XLEN-1:0]     dividend,
    input logic                neg_q,
    input logic                neg_r,
    input logic                dz,
    input logic                ovf
  );
    logic signed [XLEN-1:0] quo_s;
    logic signed [XLEN-1:0] rem_s;
    logic [XLEN-1:0]        q;
    logic [XLEN-1:0]        r;
    logic [XLEN-1:0]        sel;
    quo_s = $signed(quo);
    rem_s = $signed(rem);
    q = neg_q ? $unsigned(-quo_s) : quo;
    r = neg_r ? $unsigned(-rem_s) : rem;
    if (dz) begin
      q = '1;
      r = dividend;
    end else if (ovf) begin
      q = dividend;
      r = '0;
    end
    sel = op[DIV_OP_REM] ? r : q;
    if (op[DIV_OP_WORD]) begin
      sel = {{HW{sel[HW-1]}}, sel[HW-1:0]};
    end
    return sel;
  endfunction

  // One restoring step: shift the next dividend bit into the partial
  // remainder and keep the difference only if it did not go negative.
  // The partial remainder stays below the divisor, so XLEN+1 bits suffice.
  always_comb begin
    rem_sh    = {rem_q, quo_q[XLEN-1]};
    trial     = rem_sh - {1'b0, dvs_q};
    trial_neg = trial[XLEN];
    rem_next  = trial_neg ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
    quo_next  = {quo_q[XLEN-2:0], ~trial_neg};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      out_valid  <= 1'b0;
      div_result <= '0;
      op_q       <= '0;
      op1_q      <= '0;
      op2_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      neg_q_q    <= 1'b0;
      neg_r_q    <= 1'b0;
      cnt_q      <= '0;
    end else begin
      case (state)
        // ---- accept: latch operands, load magnitudes and counter ----
        S_IDLE: begin
          if (accept) begin
            op_q    <= div_op;
            op1_q   <= prep_op1_ext;
            op2_q   <= prep_op2_ext;
            dvs_q   <= prep_abs2;
            rem_q   <= '0;
            // Word dividends sit in the upper half so that 32 shifts
            // walk through exactly their bits.
            quo_q   <= div_op[DIV_OP_WORD] ? {prep_abs1[HW-1:0], {HW{1'b0}}}
                                           : prep_abs1;
            neg_q_q <= prep_sign_q;
            neg_r_q <= prep_sign_r;
            cnt_q   <= div_op[DIV_OP_WORD] ? CNT_HALF : CNT_FULL;
            state   <= S_CALC;
`ifdef DIV_FAST_SPECIAL_EN
            if (prep_div_zero || prep_overflow) begin
              div_result <= finalize(div_op, '0, '0, prep_op1_ext, 1'b0, 1'b0,
                                     prep_div_zero, prep_overflow);
              out_valid  <= 1'b1;
              state      <= S_DONE;
            end
`endif
          end
        end
        // ---- iterate: one quotient bit per cycle ----
        S_CALC: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            cnt_q <= cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
              state <= S_FIX;
            end
          end
        end
        // ---- fix-up: signs, special cases, word extension ----
        S_FIX: begin
          if (flush) begin
            state <= S_IDLE;
          end else begin
            div_result <= finalize(op_q, quo_q, rem_q, op1_q, neg_q_q, neg_r_q,
                                   prep_div_zero, prep_overflow);
            out_valid  <= 1'b1;
            state      <= S_DONE;
          end
        end
        // ---- hold result until the consumer takes it ----
        S_DONE: begin
          if (flush || out_ready) begin
            out_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_unit.sv
// -----------------------------------------------------------------------------
// tb_div_unit
// Self-checking bench for div_unit: directed vector table, hand-written
// handshake/flush/reset sequences and randomized operations compared with an
// arithmetic reference model.
// -----------------------------------------------------------------------------
module tb_div_unit;
  import div_unit_pkg::*;

`ifdef DIV_FAST_SPECIAL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  localparam int LAT_FULL  = 66;
  localparam int LAT_WORD  = 34;
  localparam int SPEC_FULL = FAST ? 1 : LAT_FULL;
  localparam int SPEC_WORD = FAST ? 1 : LAT_WORD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  div_op = 3'b0;
  logic [63:0] operator_1 = 64'h0;
  logic [63:0] operator_2 = 64'h0;
  logic        flush = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] div_result;

  int n_cmp  = 0;
  int n_fail = 0;

  typedef struct {
    logic [2:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] exp;
    int          lat;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  div_unit #(
    .XLEN  (64),
    .CNT_W (7)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .div_op     (div_op),
    .operator_1 (operator_1),
    .operator_2 (operator_2),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .div_result (div_result)
  );

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // RISC-V divide semantics written directly with language arithmetic
  function automatic void ref_model(input logic [2:0] op, input logic [63:0] a,
                                    input logic [63:0] b, output logic [63:0] res,
                                    output bit special);
    logic [63:0]        ua, ub, q, r;
    logic signed [63:0] sa, sb, mn;
    bit                 uns, word;
    uns  = op[0];
    word = op[2];
    if (word) begin
      ua = {32'h0, a[31:0]};
      ub = {32'h0, b[31:0]};
      sa = {{32{a[31]}}, a[31:0]};
      sb = {{32{b[31]}}, b[31:0]};
      mn = 64'shFFFF_FFFF_8000_0000;
    end else begin
      ua = a;
      ub = b;
      sa = a;
      sb = b;
      mn = 64'sh8000_0000_0000_0000;
    end
    special = 1'b0;
    if (ub == 64'h0) begin
      special = 1'b1;
      q = '1;
      r = uns ? ua : sa;
    end else if (!uns && sb == -64'sd1 && sa == mn) begin
      special = 1'b1;
      q = sa;
      r = 64'h0;
    end else if (uns) begin
      q = ua / ub;
      r = ua % ub;
    end else begin
      q = sa / sb;
      r = sa % sb;
    end
    res = op[1] ? r : q;
    if (word) res = {{32{res[31]}}, res[31:0]};
  endfunction

  task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    int guard = 0;
    while (!in_ready && guard < 200) begin
      @(posedge clk); #1;
      guard++;
    end
    div_op     = op;
    operator_1 = a;
    operator_2 = b;
    in_valid   = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    // Scramble inputs after acceptance; the unit must ignore them
    div_op     = 3'($urandom_range(0, 7));
    operator_1 = {$urandom, $urandom};
    operator_2 = {$urandom, $urandom};
  endtask

  task automatic wait_result(output logic [63:0] res, output int lat);
    lat = 1;
    while (!out_valid && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!out_valid) begin
      n_cmp++;
      n_fail++;
      $display("FAIL timeout: out_valid still low after %0d cycles, expected high", lat);
    end
    res = div_result;
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic run_check(input string name, input logic [2:0] op, input logic [63:0] a,
                           input logic [63:0] b, input logic [63:0] exp, input int exp_lat);
    logic [63:0] res;
    int          lat;
    issue(op, a, b);
    wait_result(res, lat);
    check(name, res, exp);
    check({name, "_lat"}, 64'(lat), 64'(exp_lat));
    handshake();
  endtask

  task automatic count_valid(input int cycles, output int highs);
    highs = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clk); #1;
      if (out_valid) highs++;
    end
  endtask

  initial begin
    logic [63:0] res, exp, a, b;
    logic [2:0]  op;
    int          lat, highs, mode;
    bit          spec;

    // Directed vectors: op, dividend, divisor, expected, latency
    vecs.push_back('{DivDiv,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, LAT_FULL});
    vecs.push_back('{DivRem,   64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_FULL});
    vecs.push_back('{DivDivu,  64'd100, 64'd7, 64'd14, LAT_FULL});
    vecs.push_back('{DivRemu,  64'd100, 64'd7, 64'd2, LAT_FULL});
    vecs.push_back('{DivDivu,  64'h1234, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SPEC_FULL});
    vecs.push_back('{DivRemu,  64'h1234, 64'd0, 64'h1234, SPEC_FULL});
    vecs.push_back('{DivDiv,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF,
                     64'h8000_0000_0000_0000, SPEC_FULL});
    vecs.push_back('{DivRem,   64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 64'h0, SPEC_FULL});
    vecs.push_back('{DivDivw,  64'hDEAD_BEEF_8000_0000, 64'h0000_0000_FFFF_FFFF,
                     64'hFFFF_FFFF_8000_0000, SPEC_WORD});
    vecs.push_back('{DivDivuw, 64'h0000_0000_FFFF_FFFE, 64'd1, 64'hFFFF_FFFF_FFFF_FFFE, LAT_WORD});
    vecs.push_back('{DivRemw,  64'h0000_0000_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, LAT_WORD});
    vecs.push_back('{DivDivuw, 64'h0000_0000_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, LAT_WORD});
    vecs.push_back('{DivRemuw, 64'h0000_0001_8000_0003, 64'h10, 64'd3, LAT_WORD});
    vecs.push_back('{DivDiv,   64'd5, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, SPEC_FULL});
    vecs.push_back('{DivRem,   64'hFFFF_FFFF_FFFF_FFFB, 64'd0, 64'hFFFF_FFFF_FFFF_FFFB, SPEC_FULL});
    vecs.push_back('{DivRemw,  64'h1234_5678_8765_4321, 64'hABCD_0000_0000_0000,
                     64'hFFFF_FFFF_8765_4321, SPEC_WORD});
    vecs.push_back('{DivDiv,   64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 64'hFFFF_FFFF_FFFF_FF72, LAT_FULL});
    vecs.push_back('{DivRem,   64'd1000, 64'hFFFF_FFFF_FFFF_FFF9, 64'd6, LAT_FULL});

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'h0);
    check("rst_div_result", div_result, 64'h0);
    check("rst_in_ready", 64'(in_ready), 64'h1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      run_check($sformatf("vec%0d", i), vecs[i].op, vecs[i].a, vecs[i].b,
                vecs[i].exp, vecs[i].lat);
    end

    // Backpressure: result held, new request waits for the cycle after out_ready
    issue(DivDivu, 64'd100, 64'd7);
    wait_result(res, lat);
    check("bp_lat", 64'(lat), 64'(LAT_FULL));
    div_op     = DivDivu;
    operator_1 = 64'd50;
    operator_2 = 64'd5;
    in_valid   = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      check("bp_out_valid", 64'(out_valid), 64'h1);
      check("bp_result", div_result, 64'd14);
      check("bp_in_ready", 64'(in_ready), 64'h0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("bp_release_valid", 64'(out_valid), 64'h0);
    check("bp_release_ready", 64'(in_ready), 64'h1);
    @(posedge clk); #1;
    in_valid   = 1'b0;
    operator_1 = 64'hFFFF;
    operator_2 = 64'h3;
    check("bp_next_accepted", 64'(in_ready), 64'h0);
    wait_result(res, lat);
    check("bp_next_result", res, 64'd10);
    check("bp_next_lat", 64'(lat), 64'(LAT_FULL));
    handshake();

    // Flush at CALC cycle 20
    issue(DivDivu, 64'hFFFF_0000_1234_5678, 64'd13);
    repeat (19) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_calc_idle", 64'(in_ready), 64'h1);
    check("flush_calc_valid", 64'(out_valid), 64'h0);
    count_valid(80, highs);
    check("flush_calc_no_pulse", 64'(highs), 64'h0);
    run_check("flush_calc_next", DivDivu, 64'd9, 64'd3, 64'd3, LAT_FULL);

    // Flush while in FIX
    issue(DivDivu, 64'd100, 64'd7);
    repeat (64) @(posedge clk);
    #1;
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_fix_idle", 64'(in_ready), 64'h1);
    count_valid(5, highs);
    check("flush_fix_no_pulse", 64'(highs), 64'h0);

    // Flush in DONE wins over out_ready
    issue(DivRemu, 64'd100, 64'd7);
    wait_result(res, lat);
    check("flush_done_result", res, 64'd2);
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    flush     = 1'b0;
    out_ready = 1'b0;
    check("flush_done_valid", 64'(out_valid), 64'h0);
    check("flush_done_ready", 64'(in_ready), 64'h1);

    // Flush in the accept cycle cancels the request
    div_op     = DivDivu;
    operator_1 = 64'd9;
    operator_2 = 64'd3;
    in_valid   = 1'b1;
    flush      = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    check("flush_accept_idle", 64'(in_ready), 64'h1);
    count_valid(70, highs);
    check("flush_accept_no_pulse", 64'(highs), 64'h0);

    // Asynchronous reset while DONE
    issue(DivDivu, 64'd100, 64'd7);
    wait_result(res, lat);
    #2 rst_n = 1'b0;
    #1;
    check("arst_done_valid", 64'(out_valid), 64'h0);
    check("arst_done_result", div_result, 64'h0);
    check("arst_done_ready", 64'(in_ready), 64'h1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Asynchronous reset mid-CALC
    issue(DivDiv, 64'hFFFF_FFFF_FFFF_0000, 64'd77);
    repeat (10) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("arst_calc_ready", 64'(in_ready), 64'h1);
    check("arst_calc_valid", 64'(out_valid), 64'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    run_check("arst_next", DivDivu, 64'd9, 64'd3, 64'd3, LAT_FULL);

    // Randomized operations against the reference model
    for (int n = 0; n < 200; n++) begin
      op   = 3'($urandom_range(0, 7));
      a    = {$urandom, $urandom};
      b    = {$urandom, $urandom};
      mode = $urandom_range(0, 9);
      case (mode)
        0: b = (op[2] && $urandom_range(0, 1) == 1) ? {b[63:32], 32'h0} : 64'h0;
        1: begin
          a = op[2] ? {a[63:32], 32'h8000_0000} : 64'h8000_0000_0000_0000;
          b = op[2] ? {b[63:32], 32'hFFFF_FFFF} : 64'hFFFF_FFFF_FFFF_FFFF;
        end
        2: b = 64'($urandom_range(1, 20));
        3: b = -64'($urandom_range(1, 20));
        4: a = 64'($urandom_range(0, 1000));
        5: b = {32'h0, $urandom};
        default: ;
      endcase
      ref_model(op, a, b, exp, spec);
      issue(op, a, b);
      wait_result(res, lat);
      check($sformatf("rand%0d_op%0d", n, op), res, exp);
      check($sformatf("rand%0d_lat", n), 64'(lat),
            64'((FAST && spec) ? 1 : (op[2] ? LAT_WORD : LAT_FULL)));
      handshake();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative radix-2 restoring divider for the RV64M divide/remainder group: DIV, DIVU, REM, REMU, DIVW, DIVUW, REMW, REMUW.
- The combinational ALU covers add/shift/compare/MUL. This unit is the multi-cycle inverse path and sits beside the ALU in EXU.
- Valid/ready on both sides. One operation in flight.
- A flush input from the pipeline kills the operation in progress.

Parameters:
- XLEN, 64, datapath width. Word ops use XLEN/2.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  request valid.
- in_ready  out  1  high only in IDLE.
- div_op  in  3  bit0 = unsigned, bit1 = remainder (else quotient), bit2 = word (32-bit, result sign-extended).
- operator_1  in  XLEN  dividend.
- operator_2  in  XLEN  divisor.
- flush  in  1  abort the current operation.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- div_result  out  XLEN  quotient or remainder.

Behaviour:
- Reset (async, rst_n = 0):
  - state = IDLE, out_valid = 0, div_result = 0, in_ready = 1.
  - All internal registers are cleared.
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready, latch div_op and the operands.
  - For word ops, take operand bits [31:0] and sign- or zero-extend them per bit0.
  - For signed ops, store absolute values and record sign_q = s1 ^ s2 and sign_r = s1.
  - Load the counter with N (64, or 32 when word). Go to CALC.
- CALC, one quotient bit per cycle:
  - Shift {rem, quo} left by 1.
  - trial = rem - divisor, computed at XLEN+1 bits.
  - If trial is non-negative, rem = trial and quo[0] = 1.
  - Decrement the counter. When the counter reaches 1, go to FIX.
- FIX, one cycle:
  - Negate quo if sign_q, and negate rem if sign_r.
  - Apply the special cases:
    - Divisor == 0: quotient = all ones; remainder = dividend (the original, post-width-extension value).
    - Signed overflow, dividend = most-negative and divisor = -1: quotient = dividend, remainder = 0.
  - Word ops: sign-extend bit 31 of the selected result to XLEN. This applies to DIVUW/REMUW too.
  - Register the result into div_result. Go to DONE.
- DONE:
  - out_valid = 1. div_result stays stable until the handshake.
  - On out_ready, go to IDLE and drop out_valid. The next request can be accepted in the cycle after.
- Latency: the accept at cycle T gives out_valid high at T+N+2 (66 cycles for double ops, 34 for word ops).
- Flush:
  - In CALC, FIX or DONE, flush returns the unit to IDLE next cycle with out_valid = 0 and the result discarded.
  - Flush in IDLE is ignored. Flush takes priority over out_ready.
  - A flush in the same cycle as an accept cancels that accept: the request is dropped and the unit stays in IDLE.
- Operand changes after acceptance have no effect.
- Reset mid-operation returns the unit to the reset state immediately.

Optional Feature:
- Macro: DIV_FAST_SPECIAL_EN.
- Defined:
  - Divisor == 0 and signed overflow are detected in IDLE at accept.
  - The unit goes directly to DONE with the special result. out_valid is high at T+1.
- Undefined:
  - These cases run the full N iterations and are fixed up in FIX. Latency is uniform.
- The result values are identical either way.

Decomposition:
- Shared defines header holds:
  - the div_op bit positions and encodings (DivDiv, DivDivu, DivRem, DivRemu and the W forms),
  - the state encoding,
  - the XLEN and word width constants.
  These sit next to the existing ALU op widths.
- One natural sub-module: div_prep. It is combinational and produces the width extension, the absolute values, the sign flags and the special-case detection. It is shared by IDLE-accept and FIX.

Test Plan:
- DIV -7 / 2 gives 0xFFFFFFFFFFFFFFFD. REM of the same operands gives 0xFFFFFFFFFFFFFFFF. DIVU 100 / 7 gives 14 and REMU gives 2, with out_valid at T+66.
- Divide by zero:
  - DIVU 0x1234 / 0 gives 0xFFFFFFFFFFFFFFFF, and REMU gives 0x1234.
  - With DIV_FAST_SPECIAL_EN, out_valid is at T+1; otherwise at T+66.
- DIV 0x8000000000000000 / -1 gives 0x8000000000000000, and REM gives 0.
- Word ops:
  - DIVW with op1 = 0xDEAD_BEEF_8000_0000 and op2 = 0xFFFF_FFFF gives 0xFFFFFFFF80000000, with out_valid at T+34.
  - DIVUW 0xFFFF_FFFE / 1 gives 0xFFFFFFFFFFFFFFFE.
- Backpressure: hold out_ready low for 5 cycles in DONE. out_valid and div_result must stay stable and in_ready must stay low throughout. A new in_valid is not accepted until the cycle after out_ready.
- Flush:
  - Assert flush at cycle 20 of CALC. The unit is in IDLE next cycle, no out_valid pulse appears, and the next request (DIVU 9/3) returns 3 correctly.
  - Pulse rst_n low mid-CALC. out_valid goes low asynchronously.
